// File: rtl/tcm_pam5_encoder.sv
// Trellis-coded 4D PAM-5 transmit encoder: valid/ready byte input, 8-state trellis, subset mapping.
// Optional side-stream scrambler enabled by defining TX_SCRAMBLER_EN.
module tcm_pam5_encoder #(
  parameter int          LEVEL_SCALE = 32,
  parameter logic [32:0] SCR_SEED    = 33'h1_FFFF_FFFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_txData,
  input  logic       io_txValid,
  output logic       io_txReady,
  output logic [7:0] io_txSymbols_0,
  output logic [7:0] io_txSymbols_1,
  output logic [7:0] io_txSymbols_2,
  output logic [7:0] io_txSymbols_3,
  output logic       io_txSymValid,
  output logic [2:0] io_trellisState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    FLUSH1 = 2'd2,
    FLUSH2 = 2'd3
  } state_t;

  localparam logic signed [8:0] SCALE = 9'(LEVEL_SCALE);

  state_t      state, state_next;
  logic        beat;
  logic        flush_step;
  logic        code_en;
  logic [7:0]  d_scr;
  logic [7:0]  d_word;
  logic [8:0]  sd;
  logic [2:0]  cs, cs_next;
  logic [31:0] sym_next, sym_q;
  logic        sym_valid_q;

  // Per-lane coset pattern (1 = odd-level set {-1,+1}, 0 = even set {-2,0,+2}),
  // lanes A..D from MSB; Sd[5] selects the complementary coset of the subset.
  function automatic logic [3:0] subset_cosets(input logic [2:0] s);
    logic [3:0] pat;
    case (s)
      3'd0:    pat = 4'b0000;
      3'd1:    pat = 4'b0001;
      3'd2:    pat = 4'b0011;
      3'd3:    pat = 4'b0010;
      3'd4:    pat = 4'b0110;
      3'd5:    pat = 4'b0111;
      3'd6:    pat = 4'b0101;
      default: pat = 4'b0100;
    endcase
    return pat;
  endfunction

  function automatic logic [7:0] lane_value(input logic is_odd, input logic b, input logic neg2);
    logic signed [8:0] level;
    logic signed [8:0] prod;
    if (is_odd)  level = b ? -9'sd1 : 9'sd1;
    else if (!b) level = 9'sd0;
    else         level = neg2 ? -9'sd2 : 9'sd2;
    prod = level * SCALE;
    if (prod > 9'sd127)       return 8'h7F;
    else if (prod < -9'sd127) return 8'h81;
    else                      return prod[7:0];
  endfunction

  function automatic logic [31:0] map_symbol(input logic [8:0] w);
    logic [3:0] cosets;
    cosets = subset_cosets(w[8:6]) ^ {4{w[5]}};
    return {lane_value(cosets[3], w[3], w[4]),
            lane_value(cosets[2], w[2], w[4]),
            lane_value(cosets[1], w[1], w[4]),
            lane_value(cosets[0], w[0], w[4])};
  endfunction

  // Ready depends on FSM state (and reset) only, never on io_txValid.
  assign io_txReady = reset && ((state == IDLE) || (state == DATA));
  assign beat       = io_txValid && io_txReady;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    flush_step = 1'b0;
    case (state)
      IDLE:   if (beat) state_next = DATA;
      DATA: begin
        if (!io_txValid) begin
          state_next = FLUSH1;
          flush_step = 1'b1;
        end
      end
      FLUSH1: begin
        state_next = FLUSH2;
        flush_step = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef TX_SCRAMBLER_EN
  logic [32:0] scr, scr_next;
  logic [7:0]  scr_bits;

  // x^33 + x^13 + 1, eight steps per beat; bit 0 of scr_bits is the oldest output.
  always_comb begin
    scr_next = scr;
    scr_bits = '0;
    for (int i = 0; i < 8; i++) begin
      scr_bits[i] = scr_next[32] ^ scr_next[12];
      scr_next    = {scr_next[31:0], scr_bits[i]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    scr <= SCR_SEED;
    else if (beat) scr <= scr_next;
  end

  assign d_scr = io_txData ^ scr_bits;
`else
  assign d_scr = io_txData;
`endif

  // Flush words choose d[7:6] to cancel the state bits, driving cs to zero in two steps.
  assign code_en  = beat || flush_step;
  assign d_word   = flush_step ? {cs[1], cs[0], 6'b0} : d_scr;
  assign sd       = {cs[0], d_word};
  assign cs_next  = {d_word[7] ^ cs[1], d_word[6] ^ cs[0], cs[2]};
  assign sym_next = map_symbol(sd);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cs          <= 3'd0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      state <= state_next;
      if (code_en) begin
        cs          <= cs_next;
        sym_q       <= sym_next;
        sym_valid_q <= 1'b1;
      end else begin
        sym_q       <= '0;
        sym_valid_q <= 1'b0;
      end
    end
  end

  assign io_txSymbols_0  = sym_q[31:24];
  assign io_txSymbols_1  = sym_q[23:16];
  assign io_txSymbols_2  = sym_q[15:8];
  assign io_txSymbols_3  = sym_q[7:0];
  assign io_txSymValid   = sym_valid_q;
  assign io_trellisState = cs;

endmodule
